// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch initiator: walks a PC through a combinational-read
// instruction memory and buffers pc/instruction pairs in a small prefetch FIFO.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] fetch_count
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      fetch_count_q, fetch_count_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      pc_mem_d   [FIFO_DEPTH];
  logic [31:0]      inst_mem_q [FIFO_DEPTH];
  logic [31:0]      inst_mem_d [FIFO_DEPTH];

  logic pop_s;
  logic push_s;
  logic not_empty_s;

  assign not_empty_s = (count_q != {CNT_W{1'b0}});
  assign pop_s       = not_empty_s & if_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_s      = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop_s);

  // Next-state for fetch PC, FIFO pointers/count, storage and handoff counter.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_count_d = fetch_count_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    pc_mem_d      = pc_mem_q;
    inst_mem_d    = inst_mem_q;

    if (pop_s) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = {CNT_W{1'b0}};
      head_d     = {PTR_W{1'b0}};
      tail_d     = {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        pc_mem_d[tail_q]   = fetch_pc_q;
        inst_mem_d[tail_q] = imem_inst;
        tail_d             = tail_q + PTR_W'(1);
        fetch_pc_d         = fetch_pc_q + 32'd4;
      end else begin
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      fetch_count_q <= 32'd0;
      count_q       <= {CNT_W{1'b0}};
      head_q        <= {PTR_W{1'b0}};
      tail_q        <= {PTR_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= 32'd0;
        inst_mem_q[i] <= 32'd0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fetch_count_q <= fetch_count_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      pc_mem_q      <= pc_mem_d;
      inst_mem_q    <= inst_mem_d;
    end
  end

  // Head entry is read straight from storage; empty shows a NOP at the fetch PC.
  assign imem_addr   = {fetch_pc_q[31:2], 2'b00};
  assign if_valid    = not_empty_s;
  assign if_pc       = not_empty_s ? pc_mem_q[head_q]   : fetch_pc_q;
  assign if_inst     = not_empty_s ? inst_mem_q[head_q] : NOP_INST;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the RV32I core. It drives word addresses into the combinational-read instruction memory and captures the returned instruction words.
- Fetched pc/instruction pairs are buffered in a small prefetch FIFO. The FIFO presents them to decode over a valid/ready handshake.
- Branch/jump redirects from execute flush the FIFO and restart fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch buffer entries; legal values 2 or 4.
- NOP_INST, 32'h0000_0013, instruction driven on if_inst when no entry is valid (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- fetch_en  input  1  fetch permitted this cycle
- imem_addr  output  32  byte address to instruction memory; always word aligned
- imem_inst  input  32  instruction word returned combinationally for imem_addr
- redirect_valid  input  1  control-flow redirect this cycle
- redirect_pc  input  32  redirect target; bits [1:0] ignored
- if_valid  output  1  head entry valid toward decode
- if_ready  input  1  decode accepts head entry
- if_pc  output  32  PC of head entry
- if_inst  output  32  instruction of head entry
- fetch_count  output  32  count of instructions handed to decode

Behaviour:
- Reset is synchronous and active-high. While rst=1 at a clock edge:
  - fetch_pc=RESET_PC, FIFO count=0, head/tail pointers=0, fetch_count=0.
  - No push occurs on a reset edge.
- Outputs after reset: if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, imem_addr=RESET_PC.
- imem_addr = {fetch_pc[31:2],2'b00}, combinational from the fetch_pc register.
- pop = if_valid & if_ready.
- push = fetch_en & ~redirect_valid & (count<FIFO_DEPTH | pop).
  - On push: store {fetch_pc, imem_inst} at tail, tail++ (mod FIFO_DEPTH), fetch_pc <= fetch_pc+4.
  - fetch_pc addition is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- On pop: head++, count--, fetch_count++ (wraps at 2^32).
- Push and pop in the same cycle: count is unchanged. A full FIFO with pop still accepts a push.
- Head outputs:
  - if_valid = (count!=0).
  - if_pc/if_inst come from the head entry when valid.
  - When empty: if_inst=NOP_INST and if_pc=fetch_pc.
  - Head outputs read combinationally from FIFO storage, so no extra register stage.
- Fetch latency: a push at edge N makes the entry visible on if_valid in the cycle after edge N, i.e. 1 cycle from address issue to availability. Steady-state throughput is 1 instruction/cycle with if_ready=1.
- Redirect, when redirect_valid=1 at an edge:
  - FIFO flushed: count=0, head=tail=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No push that cycle.
  - Fetch resumes at the target the following cycle, independent of fetch_en at the redirect edge.
- Redirect and pop in the same cycle: the handshake completes, so fetch_count++. All remaining entries, including any that would have been pushed, are discarded.
- Redirect while fetch_en=0: PC update and flush still occur.
- fetch_en=0: no push, fetch_pc holds. Existing entries continue to drain to decode.
- if_valid/if_pc/if_inst must stay stable while if_valid=1 & if_ready=0, unless redirect_valid flushes.
- Reset asserted mid-stream: all buffered entries are lost and state returns to reset values in the same edge. The first fetch after deassert is at RESET_PC.
- imem_inst is sampled only on push edges. Unknown imem_inst is not filtered by this block.

Test Plan:
- Reset then fetch_en=1, if_ready=1, memory word(i)=32'h1000_0000+i:
  - 1 cycle after reset deassert: if_valid=1, if_pc=0, if_inst=32'h1000_0000.
  - Then pc 4, 8, 12 on consecutive cycles; fetch_count increments every cycle.
- Backpressure, if_ready=0 for 5 cycles, FIFO_DEPTH=2:
  - count saturates at 2 and fetch_pc stops at 8.
  - if_pc holds 0 while stalled.
  - After if_ready=1: pcs 0, 4, 8, 12 in order with no gap and no duplicate.
- Redirect to 32'h0000_0103 while FIFO holds pcs 8 and 12:
  - Next cycle if_valid=0 and imem_addr=32'h100.
  - Following cycle if_pc=32'h100. Pcs 8 and 12 never appear.
- Redirect coincident with pop of head pc 20: fetch_count increments by exactly 1; the next valid if_pc is the redirect target.
- Redirect to 32'hFFFF_FFF8 with streaming: if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- fetch_en=0 with 2 buffered entries, if_ready=1:
  - Both entries drain, then if_valid=0 with if_inst=32'h0000_0013.
  - imem_addr frozen. Asserting rst mid-drain gives if_valid=0 and fetch_count=0 on the next cycle.
